// File: rtl/motor_pwm_gen.sv
// motor_pwm_gen: period-synchronous PWM generator fed by the spline-filter duty word
module motor_pwm_gen #(
    parameter int DUTY_W   = 14,
    parameter int PERIOD   = 16256,
    parameter int MIN_DUTY = 64
) (
    input  logic              clk,
    input  logic              n_rst,
    input  logic              en,
    input  logic [DUTY_W-1:0] din,
    output logic              pwm_out,
    output logic              period_start,
    output logic              busy,
    output logic [DUTY_W-1:0] duty_cur
);
    localparam int CNT_W = (PERIOD > 1) ? $clog2(PERIOD) : 1;
    localparam logic [CNT_W-1:0]  LAST = CNT_W'(PERIOD - 1);
    localparam logic [DUTY_W-1:0] FULL = DUTY_W'(PERIOD);
    localparam logic [DUTY_W-1:0] MIN  = DUTY_W'(MIN_DUTY);

    typedef enum logic {IDLE, RUN} state_t;

    state_t            state, state_n;
    logic [CNT_W-1:0]  cnt, cnt_n;
    logic [DUTY_W-1:0] duty_reg, duty_n;
    logic              ps_n, pwm_n;

    function automatic logic [DUTY_W-1:0] clamp(input logic [DUTY_W-1:0] d);
        return (d >= FULL) ? FULL : (d < MIN) ? '0 : d;
    endfunction

    // next state: a new duty is only latched when a period begins, en only matters at the boundary
    always_comb begin
        state_n = state;
        cnt_n   = '0;
        duty_n  = duty_reg;
        ps_n    = 1'b0;
        if (state == IDLE) begin
            if (en) begin
                state_n = RUN;
                duty_n  = clamp(din);
                ps_n    = 1'b1;
            end
        end else if (cnt != LAST) begin
            cnt_n = cnt + CNT_W'(1);
        end else if (en) begin
            duty_n = clamp(din);
            ps_n   = 1'b1;
        end else begin
            state_n = IDLE;
        end
        pwm_n = (state_n == RUN) && (DUTY_W'(cnt_n) < duty_n);
    end

    // state and registered outputs, all derived from next-state values so they line up with cnt
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state        <= IDLE;
            cnt          <= '0;
            duty_reg     <= '0;
            pwm_out      <= 1'b0;
            period_start <= 1'b0;
            busy         <= 1'b0;
        end else begin
            state        <= state_n;
            cnt          <= cnt_n;
            duty_reg     <= duty_n;
            pwm_out      <= pwm_n;
            period_start <= ps_n;
            busy         <= (state_n == RUN);
        end
    end

    assign duty_cur = duty_reg;
endmodule

// File: tb/tb_motor_pwm_gen.sv
// tb_motor_pwm_gen: directed plus random stimulus against a per-period waveform model
module tb_motor_pwm_gen;
    localparam int DUTY_W   = 8;
    localparam int PERIOD   = 10;
    localparam int MIN_DUTY = 2;

    logic              clk = 1'b0;
    logic              n_rst = 1'b0;
    logic              en = 1'b0;
    logic [DUTY_W-1:0] din = '0;
    logic              pwm_out, period_start, busy;
    logic [DUTY_W-1:0] duty_cur;

    int checks = 0;
    int failures = 0;

    motor_pwm_gen #(.DUTY_W(DUTY_W), .PERIOD(PERIOD), .MIN_DUTY(MIN_DUTY)) dut (
        .clk(clk), .n_rst(n_rst), .en(en), .din(din),
        .pwm_out(pwm_out), .period_start(period_start), .busy(busy), .duty_cur(duty_cur)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0d exp=%0d at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int clamp(input int d);
        return (d >= PERIOD) ? PERIOD : (d < MIN_DUTY) ? 0 : d;
    endfunction

    // model: whole-period expected waveform queued at each boundary, one entry popped per clock
    typedef struct packed {logic pwm; logic ps;} exp_t;
    exp_t q[$];
    bit   running = 0;
    int   mduty = 0;
    int   mpos = 0;

    always @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            q.delete();
            running = 0;
            mduty = 0;
        end else begin
            if (running) void'(q.pop_front());
            if (q.size() == 0) begin
                if (en) begin
                    mduty = clamp(int'(din));
                    for (int i = 0; i < PERIOD; i++) q.push_back({(i < mduty), (i == 0)});
                    running = 1;
                end else begin
                    running = 0;
                end
            end
        end
        mpos = running ? PERIOD - q.size() : 0;
    end

    // compare every cycle shortly after the active edge
    always begin
        @(posedge clk);
        #1;
        chk("pwm_out", int'(pwm_out), running ? int'(q[0].pwm) : 0);
        chk("period_start", int'(period_start), running ? int'(q[0].ps) : 0);
        chk("busy", int'(busy), int'(running));
        chk("duty_cur", int'(duty_cur), mduty);
    end

    task automatic wait_pos(input int k);
        int n = 0;
        @(negedge clk);
        while (!(running && mpos == k) && n < 60) begin
            @(negedge clk);
            n++;
        end
        chk("wait_pos_timeout", int'(n < 60), 1);
    endtask

    initial begin
        din = 5;
        repeat (30) @(negedge clk);
        n_rst = 1'b1;
        din = 3;
        en = 1'b1;
        repeat (25) @(negedge clk);
        wait_pos(5);
        din = 7;
        repeat (25) @(negedge clk);
        din = 1;
        repeat (20) @(negedge clk);
        din = 200;
        repeat (30) @(negedge clk);
        din = 4;
        wait_pos(4);
        en = 1'b0;
        repeat (20) @(negedge clk);
        en = 1'b1;
        repeat (15) @(negedge clk);
        wait_pos(2);
        chk("pwm_before_async_rst", int'(pwm_out), 1);
        #2 n_rst = 1'b0;
        #1;
        chk("async_rst_pwm", int'(pwm_out), 0);
        chk("async_rst_busy", int'(busy), 0);
        chk("async_rst_duty", int'(duty_cur), 0);
        @(negedge clk);
        n_rst = 1'b1;
        en = 1'b1;
        repeat (15) @(negedge clk);
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            if ($urandom_range(0, 3) == 0) din = DUTY_W'($urandom_range(0, 255));
            if ($urandom_range(0, 19) == 0) en = ~en;
            if (!n_rst) n_rst = 1'b1;
            else if ($urandom_range(0, 499) == 0) n_rst = 1'b0;
        end
        @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
